// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor
//
// Checker and statistics stage for a 4-bit synchronous up/down counter. It
// watches the counter output together with the controls that drive the
// counter. Each cycle it predicts the counter's next value and detects
// up-wraps (15->0) and down-wraps (0->15). It keeps a saturating tally of the
// wraps. An optional sticky error flag reports any illegal step.
//
// Optional feature macro: COUNTER_WRAP_MON_ERR_EN
//   defined   : prediction mismatch checking, the S_ERR state and the err flag
//               are compiled in.
//   undefined : err is tied to 0. Wraps are detected from the transition
//               pattern and the controls alone, and the tally never freezes.
//
// Parameters
//   WRAP_W      width of the wrap tally (minimum 2)
// Ports
//   clk         rising-edge clock (same clock as the counter)
//   rst         asynchronous active-high monitor reset
//   cnt_in      counter output value
//   cnt_rst     counter reset control (1 forces the counter to 0)
//   cnt_en      counter enable (1 = counter steps)
//   cnt_up      counter direction (1 = up, 0 = down)
//   clr         synchronous clear of tally, error and tracking
//   wrap_pulse  one-cycle pulse on a detected wrap
//   wrap_up     direction of the last wrap (1 = up), held between wraps
//   wrap_cnt    saturating wrap tally
//   err         sticky step-mismatch flag
//   tracking    high while comparing samples (S_TRACK)
module counter_wrap_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cnt_in,
  input  logic              cnt_rst,
  input  logic              cnt_en,
  input  logic              cnt_up,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic              wrap_up,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic              tracking
);

`ifdef COUNTER_WRAP_MON_ERR_EN
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_ERR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1
  } state_t;
`endif

  state_t state, state_nxt;

  // Previous-cycle sample of the counter value and its controls
  logic [3:0] prev_val;
  logic       prev_rst;
  logic       prev_en;
  logic       prev_up;

  logic       up_hit;
  logic       dn_hit;
  logic       wrap_evt;
  logic       wrap_dir;

  // Saturating increment of the wrap tally
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    if (&v) return v;
    return v + {{(WRAP_W-1){1'b0}}, 1'b1};
  endfunction

  // A counter reset is never a wrap, even from 15 to 0
  assign up_hit = !prev_rst && prev_en &&  prev_up && (prev_val == 4'd15) && (cnt_in == 4'd0);
  assign dn_hit = !prev_rst && prev_en && !prev_up && (prev_val == 4'd0)  && (cnt_in == 4'd15);

`ifdef COUNTER_WRAP_MON_ERR_EN
  logic [3:0] pred;
  logic       mismatch;
  logic       err_set;

  // Next expected counter value: reset beats enable, enable picks direction
  always_comb begin
    pred = prev_val;
    if (prev_rst)     pred = 4'd0;
    else if (prev_en) pred = prev_up ? prev_val + 4'd1 : prev_val - 4'd1;
  end

  assign mismatch = (cnt_in != pred);
`endif

  always_comb begin
    state_nxt = state;
    wrap_evt  = 1'b0;
    wrap_dir  = wrap_up;
`ifdef COUNTER_WRAP_MON_ERR_EN
    err_set   = 1'b0;
`endif
    case (state)
      S_INIT: state_nxt = S_TRACK;
      S_TRACK: begin
`ifdef COUNTER_WRAP_MON_ERR_EN
        if (mismatch) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end else
`endif
        if (up_hit || dn_hit) begin
          wrap_evt = 1'b1;
          wrap_dir = up_hit;
        end
      end
`ifdef COUNTER_WRAP_MON_ERR_EN
      // Frozen until clr or rst
      S_ERR: state_nxt = S_ERR;
`endif
      default: state_nxt = S_INIT;
    endcase
    // clr wins over any wrap or mismatch seen on the same edge
    if (clr) begin
      state_nxt = S_INIT;
      wrap_evt  = 1'b0;
`ifdef COUNTER_WRAP_MON_ERR_EN
      err_set   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      prev_val   <= 4'd0;
      prev_rst   <= 1'b0;
      prev_en    <= 1'b0;
      prev_up    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_cnt   <= '0;
      tracking   <= 1'b0;
    end else begin
      state      <= state_nxt;
      // The prev registers sample in every state, including during clr
      prev_val   <= cnt_in;
      prev_rst   <= cnt_rst;
      prev_en    <= cnt_en;
      prev_up    <= cnt_up;
      wrap_pulse <= wrap_evt;
      tracking   <= (state_nxt == S_TRACK);
      if (wrap_evt) begin
        wrap_up  <= wrap_dir;
        wrap_cnt <= sat_inc(wrap_cnt);
      end
      if (clr) wrap_cnt <= '0;
    end
  end

`ifdef COUNTER_WRAP_MON_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (clr)     err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Testbench for counter_wrap_monitor: two instances (default tally width and
// a 2-bit tally) share one stimulus stream. A reference model built from the
// counter's behaviour queues the expected outputs, and a monitor compares
// them after every clock edge.
module tb_counter_wrap_monitor;

`ifdef COUNTER_WRAP_MON_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cnt_rst, cnt_en, cnt_up, clr;
  logic [3:0] cnt_in;

  logic       wp8, wu8, er8, tr8;
  logic [7:0] wc8;
  logic       wp2, wu2, er2, tr2;
  logic [1:0] wc2;

  always #5 clk = ~clk;

  counter_wrap_monitor #(.WRAP_W(8)) dut8 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
    .cnt_up(cnt_up), .clr(clr), .wrap_pulse(wp8), .wrap_up(wu8),
    .wrap_cnt(wc8), .err(er8), .tracking(tr8));

  counter_wrap_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
    .cnt_up(cnt_up), .clr(clr), .wrap_pulse(wp2), .wrap_up(wu2),
    .wrap_cnt(wc2), .err(er2), .tracking(tr2));

  typedef struct {
    bit pulse;
    bit wup;
    bit err;
    bit trk;
    int wtot;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: phase 0 = waiting for first sample, 1 = comparing,
  // 2 = failed. The last sample is kept as plain integers.
  int ph, pv;
  bit pr, pe, pu;
  bit m_pulse, m_wup, m_err;
  int m_tot;
  int cval;  // value the real counter would present next

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_edge();
    int pred;
    bit upw, dnw;
    if (rst) begin
      ph = 0; pv = 0; pr = 0; pe = 0; pu = 0;
      m_pulse = 0; m_wup = 0; m_err = 0; m_tot = 0;
    end else begin
      m_pulse = 0;
      if (clr) begin
        m_tot = 0; m_err = 0; ph = 0;
      end else if (ph == 0) begin
        ph = 1;
      end else if (ph == 1) begin
        if (pr)      pred = 0;
        else if (pe) pred = pu ? (pv + 1) % 16 : (pv + 15) % 16;
        else         pred = pv;
        upw = !pr && pe &&  pu && pv == 15 && int'(cnt_in) == 0;
        dnw = !pr && pe && !pu && pv == 0  && int'(cnt_in) == 15;
        if (ERR_EN && int'(cnt_in) != pred) begin
          m_err = 1; ph = 2;
        end else if (upw || dnw) begin
          m_pulse = 1; m_wup = upw; m_tot++;
        end
      end
      pv = int'(cnt_in); pr = cnt_rst; pe = cnt_en; pu = cnt_up;
    end
    q.push_back('{pulse: m_pulse, wup: m_wup, err: m_err, trk: (ph == 1), wtot: m_tot});
  endfunction

  function automatic void advance_counter();
    if (cnt_rst)     cval = 0;
    else if (cnt_en) cval = cnt_up ? (cval + 1) % 16 : (cval + 15) % 16;
  endfunction

  // One clock of stimulus; g corrupts the presented value (illegal jump of +4)
  task automatic step(input bit mr, input bit r, input bit c, input bit e,
                      input bit u, input bit g);
    @(negedge clk);
    rst = mr; cnt_rst = r; clr = c; cnt_en = e; cnt_up = u;
    if (g) cval = (cval + 4) % 16;
    cnt_in = 4'(cval);
    @(posedge clk);
    model_edge();
    advance_counter();
  endtask

  task automatic up_until(input int target);
    for (int i = 0; i < 17 && cval != target; i++) step(0, 0, 0, 1, 1, 0);
  endtask

  // rst raised between edges must clear every output without waiting for clk
  task automatic async_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({wp8, wu8, wc8, er8, tr8} == 12'd0) n_pass++;
    else $display("FAIL async_rst_w8 got p=%0b u=%0b cnt=%0d err=%0b trk=%0b want all 0",
                  wp8, wu8, wc8, er8, tr8);
    n_chk++;
    if ({wp2, wu2, wc2, er2, tr2} == 6'd0) n_pass++;
    else $display("FAIL async_rst_w2 got p=%0b u=%0b cnt=%0d err=%0b trk=%0b want all 0",
                  wp2, wu2, wc2, er2, tr2);
    @(posedge clk);
    model_edge();
    advance_counter();
  endtask

  // Monitor: one expected entry per clock edge, checked 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t x;
        int w8, w2;
        x  = q.pop_front();
        w8 = min_i(x.wtot, 255);
        w2 = min_i(x.wtot, 3);
        n_chk++;
        if (wp8 == x.pulse && wu8 == x.wup && int'(wc8) == w8 && er8 == x.err && tr8 == x.trk)
          n_pass++;
        else
          $display("FAIL out_w8 t=%0t got p=%0b u=%0b cnt=%0d err=%0b trk=%0b want p=%0b u=%0b cnt=%0d err=%0b trk=%0b",
                   $time, wp8, wu8, wc8, er8, tr8, x.pulse, x.wup, w8, x.err, x.trk);
        n_chk++;
        if (wp2 == x.pulse && wu2 == x.wup && int'(wc2) == w2 && er2 == x.err && tr2 == x.trk)
          n_pass++;
        else
          $display("FAIL out_w2 t=%0t got p=%0b u=%0b cnt=%0d err=%0b trk=%0b want p=%0b u=%0b cnt=%0d err=%0b trk=%0b",
                   $time, wp2, wu2, wc2, er2, tr2, x.pulse, x.wup, w2, x.err, x.trk);
      end
    end
  end

  initial begin
    rst = 1'b1; cnt_rst = 1'b0; cnt_en = 1'b0; cnt_up = 1'b0; clr = 1'b0;
    cnt_in = 4'd0; cval = 0;
    ph = 0; pv = 0; pr = 0; pe = 0; pu = 0;
    m_pulse = 0; m_wup = 0; m_err = 0; m_tot = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Up-count wrap from 0
    repeat (20) step(0, 0, 0, 1, 1, 0);

    // Down-count wrap starting at 3
    step(0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 1, 0);
    repeat (6) step(0, 0, 0, 1, 0, 0);

    // Counter reset at 15, then hold at 0
    up_until(15);
    step(0, 1, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);

    // Illegal jump 5->9, run through 15->0, then clr
    up_until(5);
    step(0, 0, 0, 1, 1, 1);
    repeat (12) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 1, 0);

    // Saturation of the narrow tally over five more up-wraps
    repeat (80) step(0, 0, 0, 1, 1, 0);

    // Async reset with a tally of 2
    step(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 40 && m_tot < 2; i++) step(0, 0, 0, 1, 1, 0);
    async_rst();
    repeat (3) step(0, 0, 0, 1, 1, 0);

    // Randomized controls with occasional resets, clears and illegal jumps
    for (int i = 0; i < 600; i++)
      step(0, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 47) == 0);

    @(posedge clk);
    #3;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain got %0d entries left want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
